// File: rtl/huffman_queue_extractor.sv
// Consumer end of the Huffman priority queue: scans every slot, picks the two
// lowest-frequency occupied slots, hands them off as a pair, then clears both.
module huffman_queue_extractor #(
  parameter int         NUM_SLOTS = 6,
  parameter int         FREQ_W    = 32,
  parameter logic [7:0] EMPTY_POS = 8'hFF
) (
  input  logic                        clk,
  input  logic                        ctrl_reset,
  input  logic                        start,
  input  logic [8*NUM_SLOTS-1:0]      slot_pos_bus,
  input  logic [8*NUM_SLOTS-1:0]      slot_ascii_bus,
  input  logic [FREQ_W*NUM_SLOTS-1:0] slot_freq_bus,
  output logic                        busy,
  output logic                        pair_valid,
  input  logic                        pair_ready,
  output logic [2:0]                  pair_slot_a,
  output logic [2:0]                  pair_slot_b,
  output logic [7:0]                  pair_ascii_a,
  output logic [7:0]                  pair_ascii_b,
  output logic [FREQ_W-1:0]           pair_freq_a,
  output logic [FREQ_W-1:0]           pair_freq_b,
  output logic [FREQ_W:0]             pair_sum,
  output logic [2:0]                  occ_count,
  output logic                        done,
  output logic [NUM_SLOTS-1:0]        clr_wr_pos,
  output logic [7:0]                  clr_pos_data
);

  typedef enum logic [2:0] {IDLE, SCAN, PRESENT, CLEAR, DONE} stateT;

  localparam logic [2:0] LAST_IDX = 3'(NUM_SLOTS - 1);

  stateT state, nextState;

  logic [2:0]        idx;
  logic [2:0]        count;
  logic [2:0]        occCount;
  logic              min1Valid, min2Valid;
  logic [2:0]        min1Slot, min2Slot;
  logic [7:0]        min1Ascii, min2Ascii;
  logic [FREQ_W-1:0] min1Freq, min2Freq;

  logic [7:0]        curPos;
  logic [7:0]        curAscii;
  logic [FREQ_W-1:0] curFreq;
  logic              curOcc;
  logic [2:0]        scanCount;

  // Select the slot addressed by idx; scanCount includes it so the final
  // SCAN cycle can decide PRESENT vs DONE with the complete tally.
  always_comb begin
    curPos   = '0;
    curAscii = '0;
    curFreq  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx == 3'(i)) begin
        curPos   = slot_pos_bus[8*i +: 8];
        curAscii = slot_ascii_bus[8*i +: 8];
        curFreq  = slot_freq_bus[FREQ_W*i +: FREQ_W];
      end
    end
    curOcc    = (curPos != EMPTY_POS);
    scanCount = count + {2'b00, curOcc};
  end

  always_ff @(posedge clk or posedge ctrl_reset) begin
    if (ctrl_reset) state <= IDLE;
    else            state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = SCAN;
      SCAN:    if (idx == LAST_IDX) nextState = (scanCount >= 3'd2) ? PRESENT : DONE;
      PRESENT: if (pair_ready) nextState = CLEAR;
      CLEAR:   nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Strict less-than keeps the earlier (lower-index) slot on equal frequencies.
  always_ff @(posedge clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      idx       <= '0;
      count     <= '0;
      occCount  <= '0;
      min1Valid <= 1'b0;
      min2Valid <= 1'b0;
      min1Slot  <= '0;
      min2Slot  <= '0;
      min1Ascii <= '0;
      min2Ascii <= '0;
      min1Freq  <= '0;
      min2Freq  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            idx       <= '0;
            count     <= '0;
            min1Valid <= 1'b0;
            min2Valid <= 1'b0;
          end
        end
        SCAN: begin
          idx   <= idx + 3'd1;
          count <= scanCount;
          if (curOcc) begin
            if (!min1Valid || curFreq < min1Freq) begin
              min2Valid <= min1Valid;
              min2Slot  <= min1Slot;
              min2Ascii <= min1Ascii;
              min2Freq  <= min1Freq;
              min1Valid <= 1'b1;
              min1Slot  <= idx;
              min1Ascii <= curAscii;
              min1Freq  <= curFreq;
            end else if (!min2Valid || curFreq < min2Freq) begin
              min2Valid <= 1'b1;
              min2Slot  <= idx;
              min2Ascii <= curAscii;
              min2Freq  <= curFreq;
            end
          end
        end
        DONE:    occCount <= count;
        default: ;
      endcase
    end
  end

  always_comb begin
    clr_wr_pos = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      clr_wr_pos[i] = (state == CLEAR) && (min1Slot == 3'(i) || min2Slot == 3'(i));
    end
  end

  assign busy         = (state != IDLE);
  assign pair_valid   = (state == PRESENT);
  assign done         = (state == DONE);
  assign pair_slot_a  = min1Slot;
  assign pair_slot_b  = min2Slot;
  assign pair_ascii_a = min1Ascii;
  assign pair_ascii_b = min2Ascii;
  assign pair_freq_a  = min1Freq;
  assign pair_freq_b  = min2Freq;
  assign pair_sum     = {1'b0, min1Freq} + {1'b0, min2Freq};
  assign occ_count    = occCount;
  assign clr_pos_data = EMPTY_POS;

endmodule

// File: doc/huffman_queue_extractor.md
# huffman_queue_extractor

Consumer end of the 6-slot Huffman priority queue: after a `start` pulse it scans the queue-slot read buses and selects the two occupied slots with the lowest frequencies. It presents them as one pair over a valid/ready handshake, then issues a one-cycle write that marks both slots empty. It sits between the queue and the tree-building controller and runs once per merge step.

## Interface
Parameters:
- `NUM_SLOTS`, 6, number of queue slots scanned.
- `FREQ_W`, 32, frequency width per slot.
- `EMPTY_POS`, 8'hFF, queue-position value that marks a slot unoccupied.

Ports:
- `clk`  input  1  single clock; all state on rising edge.
- `ctrl_reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  one-cycle request to begin a scan; ignored while `busy`.
- `slot_pos_bus`  input  8*NUM_SLOTS  slot i queue position at [8i+7:8i].
- `slot_ascii_bus`  input  8*NUM_SLOTS  slot i ASCII at [8i+7:8i].
- `slot_freq_bus`  input  FREQ_W*NUM_SLOTS  slot i frequency at [FREQ_W*i+FREQ_W-1:FREQ_W*i].
- `busy`  output  1  high in every state except IDLE.
- `pair_valid`  output  1  selected pair is presented.
- `pair_ready`  input  1  consumer accepts the pair.
- `pair_slot_a`, `pair_slot_b`  output  3 each  slot indices: a = minimum, b = second minimum.
- `pair_ascii_a`, `pair_ascii_b`  output  8 each  ASCII of a and b.
- `pair_freq_a`, `pair_freq_b`  output  FREQ_W each  frequencies of a and b.
- `pair_sum`  output  FREQ_W+1  pair_freq_a + pair_freq_b, no truncation.
- `occ_count`  output  3  number of occupied slots found by the last scan.
- `done`  output  1  one-cycle pulse at the end of each operation.
- `clr_wr_pos`  output  NUM_SLOTS  write strobes to the queue-position fields of the slots being cleared.
- `clr_pos_data`  output  8  constant EMPTY_POS.

## Operation
- Slot i is occupied iff its position byte != EMPTY_POS.
- States:
  - IDLE: `start` -> SCAN with idx=0; min1 and min2 cleared to invalid; count=0.
  - SCAN: reads one slot per cycle at idx and increments idx. An occupied slot increments count.
    - If slot freq < min1 freq (or min1 invalid): min2 <= min1, min1 <= slot.
    - Else if freq < min2 freq (or min2 invalid): min2 <= slot.
    - Comparisons are strict, so on ties the lower slot index wins a/b.
  - After idx = NUM_SLOTS-1: count >= 2 -> PRESENT, otherwise -> DONE.
  - PRESENT: `pair_valid`=1. Pair outputs are driven from registered min1/min2. Handshake `pair_valid & pair_ready` -> CLEAR.
  - CLEAR: `clr_wr_pos` has exactly bits slot_a and slot_b set for one cycle -> DONE.
  - DONE: `done`=1 for one cycle; `occ_count` is updated to count -> IDLE.
- `occ_count` holds its value until the next DONE.
- `pair_*` data hold their last values outside PRESENT; they are meaningful only while `pair_valid`=1.
- Slot buses must be stable from `start` through the end of SCAN. Changes during PRESENT do not affect the pair outputs.

## Timing
- Reset (asynchronous, any state): state IDLE; every output 0 except `clr_pos_data`=EMPTY_POS. No clear strobe is issued for an interrupted operation.
- `start` sampled in cycle 0. SCAN covers cycles 1..NUM_SLOTS. `pair_valid` rises at cycle NUM_SLOTS+1, which is cycle 7 at the default.
- `pair_valid` stays high and all pair outputs stay stable until the handshake. `pair_ready` has no effect outside PRESENT.
- Handshake in cycle k -> `clr_wr_pos` asserted in cycle k+1 -> `done` in cycle k+2 -> IDLE in cycle k+3. A `start` in cycle k+3 is accepted.
- With count < 2: `done` occurs in cycle NUM_SLOTS+1. No `pair_valid`, no `clr_wr_pos`.
- `busy` rises in cycle 1 and falls when the state returns to IDLE. `start` while `busy` is dropped; it is not queued.

## Test plan
- All six slots occupied, freqs {5,3,9,1,7,2}, `pair_ready` high: `pair_valid` at cycle 7; a = slot 3, f=1; b = slot 5, f=2; `pair_sum`=3. `clr_wr_pos`=6'b101000 for one cycle, then `done`, then `occ_count`=6.
- All freqs 4: a = slot 0, b = slot 1, `pair_sum`=8, `clr_wr_pos`=6'b000011.
- Only slot 2 occupied (others pos=8'hFF): no `pair_valid`, no `clr_wr_pos`, `done` at cycle 7, `occ_count`=1. All empty: `occ_count`=0.
- Backpressure: `pair_ready` low for 5 cycles after `pair_valid` rises; all pair outputs stable and `clr_wr_pos`=0 throughout; clear occurs in the cycle after `pair_ready` rises.
- Slots 0 and 4 at freq 32'hFFFFFFFF, others empty: `pair_sum`=33'h1_FFFFFFFE.
- `ctrl_reset` asserted during SCAN and again during PRESENT: outputs go to 0 immediately and no clear strobe is issued. A second `start` pulsed during SCAN is ignored, giving exactly one `done`.
